// File: rtl/cpu_mem_pkg.sv
// ============================================================================
//  Module   : cpu_mem_pkg
//  Purpose  : Shared types and width defaults for the CPU memory-side blocks
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

  // Default datapath widths shared by the memory-side controllers
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 9;

  // Memory access controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ============================================================================
//  Module   : mem_wait_counter
//  Purpose  : Saturating wait-cycle counter; flags when TIMEOUT-1 is reached
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic clear,     // synchronous active-low reset
  input  logic restart,   // synchronous restart to zero
  input  logic enable,    // count one waited cycle
  output logic expired    // counter sits at TIMEOUT-1
);

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: restart wins, otherwise increment and hold at LAST
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clock) begin
    if (!clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MAR/MDR to data-RAM access controller with req/ack handshake,
//             timeout abort and Mdatain read-data capture
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] mar_q,
  input  logic [DATA_WIDTH-1:0] mdr_q,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  mem_state_t            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] mdatain_q,   mdatain_d;
  logic                  mem_req_q,   mem_req_d;
  logic                  mem_we_q,    mem_we_d;
  logic                  done_q,      done_d;
  logic                  error_q,     error_d;

  logic cnt_restart;
  logic cnt_enable;
  logic cnt_expired;

  mem_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clock   (clock),
    .clear   (clear),
    .restart (cnt_restart),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // Next-state and next-output decode; done/error are set on leaving
  // DONE/ERR so they appear together one cycle after the terminal state
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mdatain_d   = mdatain_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    error_d     = error_q;
    done_d      = 1'b0;
    cnt_restart = 1'b0;
    cnt_enable  = 1'b0;

    case (state_q)
      IDLE: begin
        if (read ^ write) begin
          mem_addr_d  = mar_q;
          if (write) begin
            mem_wdata_d = mdr_q;
          end
          mem_we_d    = write;
          mem_req_d   = 1'b1;
          error_d     = 1'b0;
          cnt_restart = 1'b1;
          state_d     = ACCESS;
        end else if (read && write) begin
          // Conflicting strobes: no memory cycle, report failure
          state_d = ERR;
        end
      end

      ACCESS: begin
        if (mem_ack) begin
          // An ack on the final wait cycle still completes normally
          if (!mem_we_q) begin
            mdatain_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_expired) begin
          mem_req_d = 1'b0;
          state_d   = ERR;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      ERR: begin
        done_d  = 1'b1;
        error_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction at once
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mdatain_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mdatain_q   <= mdatain_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign Mdatain   = mdatain_q;
  assign done      = done_q;
  assign error     = error_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller between the MAR/MDR registers and the single-port data RAM. It accepts one-cycle read or write strobes from the control unit and latches the MAR address and MDR data. It then runs a req/ack handshake with a variable-latency memory and returns read data on the Mdatain path into the MDR input mux. It is the memory-side counterpart of the BusMuxOut/Mdatain selection. Write data leaves via MDR; read data re-enters via Mdatain.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 9, memory word address width
- TIMEOUT, 16, maximum cycles waiting for mem_ack before aborting (≥2)

- clock  in  1  rising-edge clock
- clear  in  1  reset; one clock, reset is synchronous and active-low
- read  in  1  read request strobe from the control unit
- write  in  1  write request strobe from the control unit
- mar_q  in  ADDR_WIDTH  address from MAR
- mdr_q  in  DATA_WIDTH  write data from MDR
- mem_addr  out  ADDR_WIDTH  registered memory address
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_ack  in  1  memory completion; read data valid in the same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- Mdatain  out  DATA_WIDTH  captured read data to the MDR input mux
- busy  out  1  transaction in progress (any state but IDLE)
- done  out  1  one-cycle completion pulse
- error  out  1  sticky failure flag; cleared at the next accepted request

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - read xor write high → latch mar_q into mem_addr, latch mdr_q into mem_wdata (writes only), set mem_we = write, clear error, clear the wait counter, go to ACCESS.
  - read and write both high → no memory transaction; set error; go to ERR.
- ACCESS:
  - mem_req = 1.
  - mem_ack = 1 → on reads, Mdatain ← mem_rdata; go to DONE.
  - Otherwise the wait counter increments.
  - Counter = TIMEOUT-1 with no ack → set error, go to ERR.
  - Ack on the timeout cycle → ack wins, normal completion.
- DONE: done = 1, mem_req = 0, go to IDLE.
- ERR: done = 1, error = 1, mem_req = 0, go to IDLE.
- Strobes arriving while busy are ignored; the control unit must wait for done.
- mem_addr, mem_wdata and mem_we are stable for the whole ACCESS state. MAR and MDR may change freely after acceptance.
- Mdatain holds its value until the next successful read. It is not changed by writes, errors or timeouts.
- The wait counter is $clog2(TIMEOUT) bits and saturates without wrapping.

## Timing
- Reset (clear low at a rising edge) forces:
  - state = IDLE
  - mem_req, mem_we, done, busy, error = 0
  - mem_addr, mem_wdata, Mdatain = 0
  - counter = 0
- Reset mid-transaction aborts immediately. mem_req drops the following cycle and no done pulse is produced.
- All outputs are registered except busy, which is decoded from state.
- Strobe sampled at edge 0 → mem_req high from edge 0 through the edge where ack is sampled.
- Ack sampled at edge k → Mdatain updated and done high for the cycle after edge k+1. Minimum request-to-done latency is 2 cycles (ack in the first ACCESS cycle).
- mem_req falls the cycle after ack is sampled. Memory must deassert ack once req is low.
- Timeout: with no ack, ERR is entered after exactly TIMEOUT ACCESS cycles, and done and error rise together.
- A new request is accepted in the first IDLE cycle after done, giving back-to-back transactions every 3 cycles with a zero-wait memory.

## Structure
- Shared package cpu_mem_pkg holds:
  - the mem_state_t enum (IDLE, ACCESS, DONE, ERR)
  - the DATA_WIDTH and ADDR_WIDTH defaults
- One sub-module, mem_wait_counter:
  - parameterised by TIMEOUT
  - inputs: clear, enable
  - output: expired flag
  - reused by future I/O port controllers
- Top level contains the FSM and the address, data and Mdatain registers.

## Test plan
- Reset: clear low 2 cycles with read/write toggling → all outputs 0, no mem_req.
- Write, ack on second ACCESS cycle:
  - stimulus: mar_q = 9'h05A, mdr_q = 32'hDEADBEEF.
  - mem_req high 2 cycles with mem_addr = 0x05A, mem_wdata = 0xDEADBEEF, mem_we = 1.
  - done pulse once; Mdatain unchanged.
- Read, zero-wait ack:
  - stimulus: mar_q = 9'h010, mem_rdata = 32'd32.
  - Mdatain = 32 and done one cycle later; back-to-back read of 0x011 (rdata 16) → Mdatain = 16.
- Timeout: read with ack never asserted → after 16 ACCESS cycles, done and error both 1. A following good write clears error.
- Conflict and ignore:
  - read and write high together → error and done, no mem_req.
  - A strobe during ACCESS is ignored; exactly one transaction occurs.
- Reset mid-ACCESS: clear low while waiting for ack → IDLE next cycle, mem_req 0, no done, Mdatain unchanged from reset value.
